// File: rtl/bus_if.sv
// bus_if: per-stage memory access front end. SPM addresses are served combinationally,
// everything else runs a request/grant/ready transaction on the shared system bus.
module bus_if #(
    parameter logic [2:0] SPM_IDX = 3'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    input  logic [29:0] addr,
    input  logic        as_,
    input  logic        rw,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic [31:0] spm_rd_data,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_,
    input  logic        bus_grnt_,
    output logic        bus_req_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data
);

    localparam logic READ = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACCESS,
        STALL
    } state_t;

    state_t      r_state;
    logic        r_bus_req_;
    logic [29:0] r_bus_addr;
    logic        r_bus_as_;
    logic        r_bus_rw;
    logic [31:0] r_bus_wr_data;
    logic [31:0] r_rd_buf;

    logic        w_is_spm;
    logic        w_valid;

    assign w_is_spm = (addr[29:27] == SPM_IDX);
    assign w_valid  = !as_ && !flush;

    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;
    assign spm_as_     = !((r_state == IDLE) && w_valid && w_is_spm);

    assign bus_req_    = r_bus_req_;
    assign bus_addr    = r_bus_addr;
    assign bus_as_     = r_bus_as_;
    assign bus_rw      = r_bus_rw;
    assign bus_wr_data = r_bus_wr_data;

    always_comb begin
        // NOTE: defaults first so no path through the case leaves busy/rd_data unassigned (no latch).
        busy    = 1'b0;
        rd_data = '0;
        case (r_state)
            IDLE: begin
                if (w_valid && w_is_spm) begin
                    rd_data = spm_rd_data;
                end else if (w_valid) begin
                    busy = 1'b1;
                end
            end
            REQ: busy = 1'b1;
            ACCESS: begin
                if (!bus_rdy_) begin
                    rd_data = (r_bus_rw == READ) ? bus_rd_data : '0;
                end else begin
                    busy = 1'b1;
                end
            end
            STALL: rd_data = r_rd_buf;
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bus_req_    <= 1'b1;
            r_bus_addr    <= '0;
            r_bus_as_     <= 1'b1;
            r_bus_rw      <= READ;
            r_bus_wr_data <= '0;
            r_rd_buf      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid && !w_is_spm) begin
                        r_bus_req_    <= 1'b0;
                        r_bus_addr    <= addr;
                        r_bus_rw      <= rw;
                        r_bus_wr_data <= wr_data;
                        r_state       <= REQ;
                    end
                end
                REQ: begin
                    if (!bus_grnt_) begin
                        r_bus_as_ <= 1'b0;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Strobe is a single-cycle pulse regardless of slave ready timing.
                    r_bus_as_ <= 1'b1;
                    if (!bus_rdy_) begin
                        r_bus_req_ <= 1'b1;
                        if (r_bus_rw == READ) begin
                            r_rd_buf <= bus_rd_data;
                        end
                        r_state <= stall ? STALL : IDLE;
                    end
                end
                STALL: begin
                    if (!stall) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_if.sv
// Scoreboard bench for bus_if: the driver pushes expected responses and bus requests,
// a negedge monitor pops and compares them whenever the DUT presents a result.
module tb_bus_if;

    localparam logic [2:0] SPM_IDX = 3'h1;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [29:0] addr;
    logic        as_;
    logic        rw;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [31:0] spm_rd_data;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic        bus_grnt_;
    logic        bus_req_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;

    bus_if #(.SPM_IDX(SPM_IDX)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
        .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
        .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_),
        .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_),
        .bus_rw(bus_rw), .bus_wr_data(bus_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        spm_as;
        logic        req;
        int          wait_c;
        logic [29:0] saddr;
        logic        srw;
        logic [31:0] swd;
    } resp_t;

    typedef struct {
        logic [29:0] a;
        logic        rw;
        logic [31:0] wd;
    } breq_t;

    resp_t       resp_q[$];
    breq_t       breq_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          run = 0;
    logic [31:0] m_rd_buf = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_resp(input logic [31:0] rd, input logic sa, input logic rq, input int w);
        resp_t r;
        r.rd = rd; r.spm_as = sa; r.req = rq; r.wait_c = w;
        r.saddr = addr; r.srw = rw; r.swd = wr_data;
        resp_q.push_back(r);
    endfunction

    // Monitor: a result is presented whenever busy is low and the stage is either
    // accessing or holding a stalled result.
    always @(negedge clk) begin
        resp_t r;
        breq_t b;
        if (reset) begin
            run = 0;
        end else if (busy) begin
            run++;
        end else begin
            if (!as_ || stall) begin
                if (resp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL resp_unexpected: got rd_data %h expected no response at %0t", rd_data, $time);
                end else begin
                    r = resp_q.pop_front();
                    check("rd_data", rd_data, r.rd);
                    check("spm_as_", 32'(spm_as_), 32'(r.spm_as));
                    check("bus_req_", 32'(bus_req_), 32'(r.req));
                    check("busy_cycles", 32'(run), 32'(r.wait_c));
                    check("spm_addr", 32'(spm_addr), 32'(r.saddr));
                    check("spm_rw", 32'(spm_rw), 32'(r.srw));
                    check("spm_wr_data", spm_wr_data, r.swd);
                end
            end
            run = 0;
        end
        if (!reset && !bus_as_) begin
            if (breq_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL bus_as_unexpected: got bus_as_ 0 expected 1 at %0t", $time);
            end else begin
                b = breq_q.pop_front();
                check("bus_addr", 32'(bus_addr), 32'(b.a));
                check("bus_rw", 32'(bus_rw), 32'(b.rw));
                check("bus_wr_data", bus_wr_data, b.wd);
                check("bus_req_at_as", 32'(bus_req_), 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        as_ = 1'b1; stall = 1'b0; flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        cyc();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus_req_"}, 32'(bus_req_), 32'd1);
        check({tag, "_bus_as_"}, 32'(bus_as_), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
        check({tag, "_bus_rw"}, 32'(bus_rw), 32'd1);
        check({tag, "_bus_wr_data"}, bus_wr_data, 32'd0);
        check({tag, "_rd_data"}, rd_data, 32'd0);
        check({tag, "_spm_as_"}, 32'(spm_as_), 32'd1);
    endtask

    task automatic spm_acc(input logic [29:0] a, input logic r, input logic [31:0] wd, input logic [31:0] sd);
        as_ = 1'b0; flush = 1'b0; stall = 1'b0;
        addr = a; rw = r; wr_data = wd; spm_rd_data = sd;
        push_resp(sd, 1'b0, 1'b1, 0);
        cyc();
    endtask

    task automatic flush_acc(input logic [29:0] a);
        as_ = 1'b0; flush = 1'b1; stall = 1'b0;
        addr = a; rw = 1'($urandom_range(0, 1)); wr_data = $urandom;
        push_resp(32'd0, 1'b1, 1'b1, 0);
        cyc();
        check("flush_no_bus_req_", 32'(bus_req_), 32'd1);
        idle();
    endtask

    // One bus transaction: g wait cycles before grant, rw_ wait cycles before ready,
    // st stalled cycles after ready; optionally reset in the first ACCESS cycle.
    task automatic bus_acc(input logic [29:0] a, input logic r, input logic [31:0] wd,
                           input logic [31:0] rdv, input int g, input int rw_, input int st,
                           input bit flush_mid, input bit do_reset);
        breq_t b;
        as_ = 1'b0; flush = 1'b0; stall = 1'b0;
        addr = a; rw = r; wr_data = wd; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        b.a = a; b.rw = r; b.wd = wd;
        breq_q.push_back(b);
        cyc();
        for (int i = 0; i <= g; i++) begin
            bus_grnt_ = (i == g) ? 1'b0 : 1'b1;
            flush = flush_mid;
            addr = 30'($urandom); rw = 1'($urandom_range(0, 1)); wr_data = $urandom;
            cyc();
        end
        bus_grnt_ = 1'b1;
        if (do_reset) begin
            bus_rdy_ = 1'b1;
            @(negedge clk);
            #2;
            reset = 1'b1; as_ = 1'b1; flush = 1'b0;
            #1;
            check_reset_outputs("rst_mid");
            @(posedge clk);
            @(negedge clk);
            #1;
            reset = 1'b0;
            m_rd_buf = '0;
            cyc();
            return;
        end
        for (int j = 0; j <= rw_; j++) begin
            flush = flush_mid;
            if (j == rw_) begin
                bus_rdy_ = 1'b0; bus_rd_data = rdv; stall = (st > 0);
                push_resp(r ? rdv : 32'd0, 1'b1, 1'b0, g + rw_ + 2);
            end else begin
                bus_rdy_ = 1'b1; bus_rd_data = $urandom;
            end
            cyc();
        end
        bus_rdy_ = 1'b1; flush = 1'b0;
        if (r) m_rd_buf = rdv;
        for (int k = 0; k < st; k++) begin
            as_ = 1'b1; stall = 1'b1;
            push_resp(m_rd_buf, 1'b1, 1'b1, 0);
            cyc();
        end
        if (st > 0) idle();
    endtask

    function automatic logic [29:0] rand_bus_addr();
        logic [29:0] a;
        a = 30'($urandom);
        if (a[29:27] == SPM_IDX) a[29:27] = a[29:27] ^ 3'b100;
        return a;
    endfunction

    function automatic logic [29:0] rand_spm_addr();
        logic [29:0] a;
        a = 30'($urandom);
        a[29:27] = SPM_IDX;
        return a;
    endfunction

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
        addr = '0; wr_data = '0; spm_rd_data = '0; bus_rd_data = '0;
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        #12;
        check_reset_outputs("rst_init");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();

        spm_acc(30'h0800_0010, 1'b1, 32'h0, 32'hCAFE_0001);
        bus_acc(30'h0000_0040, 1'b1, 32'h0, 32'h1234_5678, 2, 1, 0, 1'b0, 1'b0);
        bus_acc(30'h0000_0080, 1'b0, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1, 0, 0, 1'b0, 1'b0);
        bus_acc(30'h0000_0040, 1'b1, 32'h0, 32'h1234_5678, 0, 0, 3, 1'b0, 1'b0);
        flush_acc(30'h0800_0020);
        flush_acc(30'h0000_0100);
        bus_acc(30'h0000_0200, 1'b1, 32'h0, 32'h0BAD_F00D, 1, 1, 0, 1'b1, 1'b0);
        bus_acc(30'h0000_0300, 1'b1, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b1);
        bus_acc(30'h0000_0400, 1'b0, 32'h5555_AAAA, 32'h7777_7777, 0, 0, 2, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: spm_acc(rand_spm_addr(), 1'($urandom_range(0, 1)), $urandom, $urandom);
                3, 4, 5, 6, 7:
                    bus_acc(rand_bus_addr(), 1'($urandom_range(0, 1)), $urandom, $urandom,
                            $urandom_range(0, 3), $urandom_range(0, 3),
                            ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                            1'($urandom_range(0, 1)), 1'b0);
                8: flush_acc(30'($urandom));
                default: begin
                    if ($urandom_range(0, 3) == 0)
                        bus_acc(rand_bus_addr(), 1'b1, $urandom, $urandom, $urandom_range(0, 2), 0, 0, 1'b0, 1'b1);
                    else
                        idle();
                end
            endcase
        end

        idle();
        idle();
        check("resp_q_left", 32'(resp_q.size()), 32'd0);
        check("breq_q_left", 32'(breq_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_if.md
# bus_if

Per-stage memory access front end for the CPU pipeline, one instance each for the IF and MEM stages. Decodes each pipeline access: scratch-pad (SPM) addresses go straight to one port of the dual-port SPM, all others run a request/grant/ready transaction on the shared system bus. Stalls the pipeline through `busy` while a bus transaction is outstanding. Buffers bus read data while the pipeline is held.

## Interface
- `SPM_IDX`, default 3'h1: value of address bits [29:27] that selects the SPM.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `stall  in  1`: pipeline stall; high holds the current stage.
- `flush  in  1`: pipeline flush; high suppresses a new access in IDLE.
- `busy  out  1`: high while a bus access is unfinished; drives the pipeline stall.
- `addr  in  30`: CPU word address (`WordAddrBus`).
- `as_  in  1`: CPU access strobe, active low.
- `rw  in  1`: `READ`=1, `WRITE`=0.
- `wr_data  in  32`: CPU write data (`WordDataBus`).
- `rd_data  out  32`: read data returned to the stage.
- `spm_rd_data  in  32`: SPM port read data.
- `spm_addr  out  30`: SPM port address; equals `addr`.
- `spm_as_  out  1`: SPM strobe, active low.
- `spm_rw  out  1`: SPM read/write; equals `rw`.
- `spm_wr_data  out  32`: SPM write data; equals `wr_data`.
- `bus_rd_data  in  32`: bus read data.
- `bus_rdy_  in  1`: slave ready, active low.
- `bus_grnt_  in  1`: arbiter grant, active low.
- `bus_req_  out  1`: bus request, active low; registered.
- `bus_addr  out  30`: bus address; registered.
- `bus_as_  out  1`: bus strobe, active low; registered.
- `bus_rw  out  1`: bus read/write; registered.
- `bus_wr_data  out  32`: bus write data; registered.

## Operation
- Decode: `is_spm` = (addr[29:27] == SPM_IDX). `valid` = (as_==0) && (flush==0).
- SPM path is combinational in every state:
  - `spm_as_` = 0 only when state==IDLE, `valid`, and `is_spm`; otherwise 1.
- State machine: IDLE, REQ, ACCESS, STALL.
- IDLE:
  - `valid` && `is_spm`: `rd_data` = `spm_rd_data`, `busy` = 0, no state change.
  - `valid` && !`is_spm`: `busy` = 1. At the edge, `bus_req_`←0; `bus_addr`, `bus_rw`, `bus_wr_data` latch the CPU values; go to REQ.
  - Otherwise: `rd_data` = 0, `busy` = 0.
- REQ:
  - `busy` = 1 and `bus_req_` stays low.
  - When `bus_grnt_`==0: `bus_as_`←0 for exactly one cycle and go to ACCESS.
- ACCESS:
  - `bus_as_`←1 at the first edge. `busy` = 1 until `bus_rdy_`==0.
  - In the `bus_rdy_`==0 cycle:
    - `busy` = 0.
    - `rd_data` = `bus_rd_data` on a read, 0 on a write.
    - At the edge: `bus_req_`←1, and `rd_buf`←`bus_rd_data` on a read.
    - Next state is STALL if `stall`==1, otherwise IDLE.
- STALL:
  - `busy` = 0 and `rd_data` = `rd_buf`.
  - Returns to IDLE on the first cycle with `stall`==0.
- `flush` affects IDLE only. A bus transaction in REQ or ACCESS always completes, so the bus is never abandoned mid-cycle.
- Address, rw and write data on the bus come from the latched registers, not the live CPU inputs. CPU-side changes after IDLE are ignored.
- Reset (asserted at any time, including mid-transaction):
  - State→IDLE.
  - `bus_req_`=1, `bus_as_`=1, `bus_addr`=0, `bus_rw`=`READ`, `bus_wr_data`=0, `rd_buf`=0.
  - Combinational outputs follow from IDLE: `busy`=0, `rd_data`=0 with no access, `spm_as_`=1 with no access.

## Timing
- SPM access: zero added cycles. Strobe, data and `busy`=0 all occur in the request cycle.
- Bus access, best case (grant and ready immediate): 3 cycles.
  - Cycle 0: IDLE decodes the access, `busy`=1.
  - Cycle 1: REQ sees `bus_grnt_`=0.
  - Cycle 2: ACCESS sees `bus_rdy_`=0; `busy`=0 and data is valid.
- Each extra cycle of grant or ready wait adds exactly one cycle.
- `bus_as_` is low for exactly one cycle per transaction. `bus_req_` stays low from cycle 1 through the ready cycle inclusive.
- `busy` and `rd_data` are combinational from state and inputs. All bus outputs are registered.

## Test plan
- SPM read: addr=30'h0800_0010 (index 1), as_=0, rw=READ, spm_rd_data=32'hCAFE_0001 → same cycle: `spm_as_`=0, `rd_data`=32'hCAFE_0001, `busy`=0, `bus_req_` stays 1.
- Bus read with grant 2 cycles late and ready 1 cycle late: addr=30'h0000_0040 → `busy`=1 for 5 cycles; `bus_as_` low 1 cycle with `bus_addr`=30'h40; on ready `rd_data`=`bus_rd_data`=32'h1234_5678 and `busy`=0.
- Bus write: rw=WRITE, wr_data=32'hA5A5_A5A5 → `bus_rw`=0 and `bus_wr_data`=32'hA5A5_A5A5 while `bus_as_`=0; `rd_data`=0 on completion.
- Stall after bus read: hold `stall`=1 for 3 cycles after ready → FSM in STALL, `rd_data` holds 32'h1234_5678, `busy`=0; returns to IDLE when `stall` drops.
- Flush in IDLE with as_=0 → no `spm_as_` and no `bus_req_`. Flush asserted during REQ → transaction still completes.
- Reset asserted in ACCESS → `bus_req_`=1 and `bus_as_`=1 immediately (asynchronous); `busy`=0; next access starts cleanly from IDLE.
